bp_be_regfile_ctrl: RTL and testbench

//  Scoreboard and write-port controller for the 32-entry RV64 integer register file.
//  - Gates instruction issue on RAW and WAW hazards against long-latency results still in flight.
//  - Arbitrates the single RF write port between the fixed-latency pipe (fast) and the

---
 rtl/bp_be_regfile_ctrl.sv | 95 +++++++++
 tb/tb_bp_be_regfile_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bp_be_regfile_ctrl.sv
// bp_be_regfile_ctrl: issue scoreboard and single RF write-port arbiter (fast > skid buffer > slow)
module bp_be_regfile_ctrl #(
  parameter int rf_els_p = 32,
  parameter int reg_addr_width_p = 5,
  parameter int data_width_p = 64,
  parameter int instr_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        instr_v_i,
  input  logic [instr_width_p-1:0]    instr_i,
  input  logic                        instr_uses_rs1_i,
  input  logic                        instr_uses_rs2_i,
  input  logic                        instr_long_i,
  output logic                        instr_ready_o,
  input  logic                        fast_v_i,
  input  logic [reg_addr_width_p-1:0] fast_addr_i,
  input  logic [data_width_p-1:0]     fast_data_i,
  input  logic                        slow_v_i,
  input  logic [reg_addr_width_p-1:0] slow_addr_i,
  input  logic [data_width_p-1:0]     slow_data_i,
  output logic                        slow_ready_o,
  input  logic                        flush_i,
  output logic                        rf_w_v_o,
  output logic [reg_addr_width_p-1:0] rf_w_addr_o,
  output logic [data_width_p-1:0]     rf_w_data_o,
  output logic [rf_els_p-1:0]         pending_o
);
  typedef enum logic {RUN, DRAIN} state_e;
  state_e state_r, state_n;
  logic [rf_els_p-1:0] pending_r, pending_n, set_mask, clr_mask, one;
  logic buf_v_r, buf_v_n;
  logic [reg_addr_width_p-1:0] buf_addr_r, rd, rs1, rs2, w_addr, clr_addr;
  logic [data_width_p-1:0] buf_data_r, w_data;
  logic rs1_haz, rs2_haz, waw, issue, slow_acc, w_v, clr_v;
  logic unused_instr;
  assign unused_instr = ^{instr_i[instr_width_p-1:25], instr_i[14:12], instr_i[6:0]};
  assign one = {{(rf_els_p-1){1'b0}}, 1'b1};
  assign rd  = instr_i[11:7];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign rs1_haz = instr_uses_rs1_i & |rs1 & pending_r[rs1];
  assign rs2_haz = instr_uses_rs2_i & |rs2 & pending_r[rs2];
  assign waw = instr_long_i & |rd & pending_r[rd];
  assign instr_ready_o = (state_r == RUN) & ~flush_i & ~rs1_haz & ~rs2_haz & ~waw;
  assign issue = instr_v_i & instr_ready_o;
  assign slow_ready_o = ~buf_v_r;
  assign slow_acc = slow_v_i & ~buf_v_r;
  assign pending_o = pending_r;
  // A slow result is only retired (pending cleared) when it actually reaches rf_w_*
  always_comb begin
    w_v = fast_v_i | buf_v_r | slow_acc;
    w_addr = fast_v_i ? fast_addr_i : buf_v_r ? buf_addr_r : slow_addr_i;
    w_data = fast_v_i ? fast_data_i : buf_v_r ? buf_data_r : slow_data_i;
    clr_v = ~fast_v_i & (buf_v_r | slow_acc);
    clr_addr = buf_v_r ? buf_addr_r : slow_addr_i;
    buf_v_n = fast_v_i & (buf_v_r | slow_acc);
    set_mask = (issue & instr_long_i & |rd) ? one << rd : '0;
    clr_mask = clr_v ? one << clr_addr : '0;
    pending_n = (pending_r & ~clr_mask) | set_mask;
    state_n = (state_r == RUN) ? (flush_i ? DRAIN : RUN)
            : (flush_i | |pending_r | buf_v_r) ? DRAIN : RUN;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= RUN;
      pending_r <= '0;
      buf_v_r <= 1'b0;
      buf_addr_r <= '0;
      buf_data_r <= '0;
      rf_w_v_o <= 1'b0;
      rf_w_addr_o <= '0;
      rf_w_data_o <= '0;
    end else begin
      state_r <= state_n;
      pending_r <= pending_n;
      buf_v_r <= buf_v_n;
      if (fast_v_i & slow_acc) begin
        buf_addr_r <= slow_addr_i;
        buf_data_r <= slow_data_i;
      end
      rf_w_v_o <= w_v & |w_addr;
      if (w_v) begin
        rf_w_addr_o <= w_addr;
        rf_w_data_o <= w_data;
      end
    end
  end
  a_slow_pending: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(slow_acc && |slow_addr_i && !pending_r[slow_addr_i]));
  a_set_clr: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (set_mask & clr_mask) == '0);
  a_fast_pending: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fast_v_i && |fast_addr_i && pending_r[fast_addr_i]));
endmodule

// File: tb/tb_bp_be_regfile_ctrl.sv
// tb_bp_be_regfile_ctrl: directed vectors checked against a queue-based scoreboard model every cycle
module tb_bp_be_regfile_ctrl;
  logic clk = 0, reset_n = 0;
  logic instr_v, uses1, uses2, lng, fast_v, slow_v, flush;
  logic [31:0] instr;
  logic [4:0] fast_addr, slow_addr;
  logic [63:0] fast_data, slow_data;
  logic ready, slow_ready, rf_w_v;
  logic [4:0] rf_w_addr;
  logic [63:0] rf_w_data;
  logic [31:0] pending;
  int errors = 0, checks = 0;
  bp_be_regfile_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .instr_v_i(instr_v), .instr_i(instr),
    .instr_uses_rs1_i(uses1), .instr_uses_rs2_i(uses2), .instr_long_i(lng),
    .instr_ready_o(ready), .fast_v_i(fast_v), .fast_addr_i(fast_addr), .fast_data_i(fast_data),
    .slow_v_i(slow_v), .slow_addr_i(slow_addr), .slow_data_i(slow_data), .slow_ready_o(slow_ready),
    .flush_i(flush), .rf_w_v_o(rf_w_v), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data),
    .pending_o(pending)
  );
  always #5 clk = ~clk;
  typedef struct {logic [4:0] a; logic [63:0] d;} wr_t;
  bit mpend[32];
  wr_t wq[$];
  bit mdrain = 0, ewv = 0;
  logic [4:0] ewa = 0;
  logic [63:0] ewd = 0;
  function automatic logic [31:0] mk(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] mpend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction
  function automatic bit exp_ready();
    logic [4:0] rd = instr[11:7], r1 = instr[19:15], r2 = instr[24:20];
    if (mdrain || flush) return 0;
    if (uses1 && r1 != 0 && mpend[r1]) return 0;
    if (uses2 && r2 != 0 && mpend[r2]) return 0;
    if (lng && rd != 0 && mpend[rd]) return 0;
    return 1;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // model: slow results queue behind the fast write; only one can be waiting
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      foreach (mpend[i]) mpend[i] = 0;
      wq = {};
      mdrain = 0; ewv = 0; ewa = 0; ewd = 0;
    end else begin
      bit rdy, idle_now;
      wr_t s[$];
      rdy = exp_ready();
      idle_now = (mpend_vec() == 0) && (wq.size() == 0);
      s = wq;
      if (slow_v && wq.size() == 0) s.push_back('{slow_addr, slow_data});
      ewv = 0;
      if (fast_v) begin
        ewv = fast_addr != 0; ewa = fast_addr; ewd = fast_data;
      end else if (s.size() > 0) begin
        ewv = s[0].a != 0; ewa = s[0].a; ewd = s[0].d;
        mpend[s[0].a] = 0;
        void'(s.pop_front());
      end
      wq = s;
      if (instr_v && rdy && lng && instr[11:7] != 0) mpend[instr[11:7]] = 1;
      mdrain = mdrain ? (flush || !idle_now) : flush;
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("m_ready", ready, exp_ready());
      chk("m_slow_ready", slow_ready, wq.size() == 0);
      chk("m_pending", pending, mpend_vec());
      chk("m_rf_w_v", rf_w_v, ewv);
      chk("m_rf_w_addr", rf_w_addr, ewa);
      chk("m_rf_w_data", rf_w_data, ewd);
    end
  end
  task automatic idle();
    instr_v = 0; instr = 0; uses1 = 0; uses2 = 0; lng = 0; flush = 0;
    fast_v = 0; fast_addr = 0; fast_data = 0; slow_v = 0; slow_addr = 0; slow_data = 0;
  endtask
  task automatic to_neg(); @(negedge clk); endtask
  task automatic to_drv(); @(posedge clk); #1; idle(); endtask
  task automatic issue(logic [4:0] rd, logic [4:0] r1, logic [4:0] r2, bit u1, bit u2, bit l);
    instr_v = 1; instr = mk(rd, r1, r2); uses1 = u1; uses2 = u2; lng = l;
  endtask
  initial begin
    idle();
    repeat (2) to_neg();
    chk("rst_pending", pending, 0);
    chk("rst_rf_w_v", rf_w_v, 0);
    chk("rst_slow_ready", slow_ready, 1);
    to_drv(); reset_n = 1;
    issue(1, 2, 3, 1, 1, 0);
    to_neg(); chk("t1_ready", ready, 1); chk("t1_rf_w_v", rf_w_v, 0); chk("t1_pending", pending, 0);
    to_drv(); issue(5, 0, 0, 0, 0, 1);
    to_neg(); chk("t2_long_ready", ready, 1);
    to_drv(); issue(6, 5, 0, 1, 0, 0);
    to_neg(); chk("t2_raw_ready", ready, 0); chk("t2_pending", pending, 32'h20);
    to_drv(); issue(6, 5, 0, 1, 0, 0); slow_v = 1; slow_addr = 5; slow_data = 64'h55;
    to_neg(); chk("t2_wb_ready", ready, 0);
    to_drv(); issue(6, 5, 0, 1, 0, 0);
    to_neg(); chk("t2_rf_w_v", rf_w_v, 1); chk("t2_rf_addr", rf_w_addr, 5);
    chk("t2_rf_data", rf_w_data, 64'h55); chk("t2_dep_ready", ready, 1);
    to_drv(); issue(7, 0, 0, 0, 0, 1);
    to_neg();
    to_drv(); fast_v = 1; fast_addr = 3; fast_data = 64'hAA; slow_v = 1; slow_addr = 7; slow_data = 64'hBB;
    to_neg(); chk("t3_sr0", slow_ready, 1);
    to_drv();
    to_neg(); chk("t3_addr1", rf_w_addr, 3); chk("t3_data1", rf_w_data, 64'hAA);
    chk("t3_sr1", slow_ready, 0); chk("t3_pend1", pending, 32'h80);
    to_drv();
    to_neg(); chk("t3_v2", rf_w_v, 1); chk("t3_addr2", rf_w_addr, 7); chk("t3_data2", rf_w_data, 64'hBB);
    chk("t3_pend2", pending, 0);
    to_drv(); issue(0, 0, 0, 0, 0, 1);
    to_neg(); chk("t4_ready", ready, 1);
    to_drv();
    to_neg(); chk("t4_pending", pending, 0);
    to_drv(); slow_v = 1; slow_addr = 0; slow_data = 64'h11;
    to_neg(); chk("t4_sr", slow_ready, 1);
    to_drv();
    to_neg(); chk("t4_rf_w_v", rf_w_v, 0); chk("t4_sr2", slow_ready, 1);
    to_drv(); issue(2, 0, 0, 0, 0, 1);
    to_neg();
    to_drv(); issue(9, 0, 0, 0, 0, 1);
    to_neg();
    to_drv(); flush = 1;
    to_neg(); chk("t5_flush_ready", ready, 0); chk("t5_pending", pending, 32'h204);
    to_drv(); issue(1, 0, 0, 0, 0, 0); slow_v = 1; slow_addr = 2; slow_data = 64'h22;
    to_neg(); chk("t5_c1_ready", ready, 0);
    to_drv(); issue(1, 0, 0, 0, 0, 0); slow_v = 1; slow_addr = 9; slow_data = 64'h99;
    to_neg(); chk("t5_c2_ready", ready, 0); chk("t5_c2_pend", pending, 32'h200);
    to_drv(); issue(1, 0, 0, 0, 0, 0);
    to_neg(); chk("t5_c3_ready", ready, 0); chk("t5_c3_pend", pending, 0);
    to_drv(); issue(1, 0, 0, 0, 0, 0);
    to_neg(); chk("t5_c4_ready", ready, 1);
    to_drv(); issue(4, 0, 0, 0, 0, 1);
    to_neg();
    to_drv(); fast_v = 1; fast_addr = 1; fast_data = 64'h1; slow_v = 1; slow_addr = 4; slow_data = 64'h44;
    to_neg();
    to_drv();
    #2; chk("t6_pre_sr", slow_ready, 0); chk("t6_pre_pend", pending, 32'h10);
    reset_n = 0;
    #1; chk("t6_pend", pending, 0); chk("t6_rf_w_v", rf_w_v, 0); chk("t6_sr", slow_ready, 1);
    to_drv(); reset_n = 1;
    repeat (3) to_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
